// File: rtl/delay.sv
// Cycle delay used by the boot sequencer for its timed waits.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high
//   enable  in   count while high; low clears the count
//   done    out  high in the DURATION-th consecutive enabled cycle
//
// CONTINUOUS=0 holds done high once reached, until enable drops.
// CONTINUOUS=1 restarts the count after every done.
module delay #(
    parameter int unsigned DURATION   = 16,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic done
);

    localparam int unsigned    W    = $clog2(DURATION + 1);
    localparam logic [W-1:0]   LAST = W'(DURATION - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= CONTINUOUS ? '0 : LAST;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done = enable && (count_q == LAST);

endmodule

// File: rtl/boot_sequencer.sv
// Power-on sequencer: waits for PLL lock to settle, wakes the SPI flash,
// starts the ROM loader (with retries) and releases the CPU reset once the
// program image is in place.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high
//   pll_locked    in   PLL lock, already synchronised to clk
//   loader_done   in   ROM loader finished (level)
//   flash_wake    out  1-cycle pulse: release flash from deep power-down
//   loader_start  out  1-cycle pulse: begin image copy
//   cpu_reset     out  high until the image is loaded
//   ready         out  high in RUN only
//   fault         out  high in FAULT only
//   attempts      out  load attempts this boot, saturates at MAX_RETRIES
module boot_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES   = 48,
    parameter int unsigned LOAD_TIMEOUT  = 65536,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       loader_done,
    output logic       flash_wake,
    output logic       loader_start,
    output logic       cpu_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] attempts
);

    localparam logic [3:0] MAX_ATTEMPTS = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StSettle   = 3'd1,
        StWake     = 3'd2,
        StWakeWait = 3'd3,
        StLoad     = 3'd4,
        StLoadWait = 3'd5,
        StRun      = 3'd6,
        StFault    = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic       settle_en, settle_done;
    logic       wake_en, wake_done;
    logic       load_en, load_timeout;
    logic       done_armed_q;
    logic [3:0] attempts_q;

    assign settle_en = (state_q == StSettle);
    assign wake_en   = (state_q == StWakeWait);
    // Timeout is measured from the loader_start cycle, so the LOAD cycle counts too.
    assign load_en   = (state_q == StLoad) || (state_q == StLoadWait);

    delay #(
        .DURATION   (SETTLE_CYCLES),
        .CONTINUOUS (1'b0)
    ) u_settle (
        .clk    (clk),
        .reset  (reset),
        .enable (settle_en),
        .done   (settle_done)
    );

    delay #(
        .DURATION   (WAKE_CYCLES),
        .CONTINUOUS (1'b0)
    ) u_wake (
        .clk    (clk),
        .reset  (reset),
        .enable (wake_en),
        .done   (wake_done)
    );

    delay #(
        .DURATION   (LOAD_TIMEOUT),
        .CONTINUOUS (1'b0)
    ) u_load (
        .clk    (clk),
        .reset  (reset),
        .enable (load_en),
        .done   (load_timeout)
    );

    always_comb begin
        state_d = state_q;
        if (state_q != StWaitLock && !pll_locked) begin
            state_d = StWaitLock;
        end else begin
            unique case (state_q)
                StWaitLock: if (pll_locked) state_d = StSettle;
                StSettle:   if (settle_done) state_d = StWake;
                StWake:     state_d = StWakeWait;
                StWakeWait: if (wake_done) state_d = StLoad;
                StLoad:     state_d = StLoadWait;
                StLoadWait: begin
                    // done_armed_q masks a stale done level on the first LOAD_WAIT cycle.
                    if (loader_done && done_armed_q) begin
                        state_d = StRun;
                    end else if (load_timeout) begin
                        state_d = (attempts_q < MAX_ATTEMPTS) ? StWake : StFault;
                    end
                end
                StRun:      state_d = StRun;
                StFault:    state_d = StFault;
                default:    state_d = StWaitLock;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StWaitLock;
            done_armed_q <= 1'b0;
            attempts_q   <= '0;
            flash_wake   <= 1'b0;
            loader_start <= 1'b0;
            cpu_reset    <= 1'b1;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_armed_q <= (state_q == StLoadWait) && (state_d == StLoadWait);
            if (state_d == StWaitLock) begin
                attempts_q <= '0;
            end else if (state_d == StLoad && attempts_q < MAX_ATTEMPTS) begin
                attempts_q <= attempts_q + 1'b1;
            end
            // Outputs decode the next state so they line up with the registered state.
            flash_wake   <= (state_d == StWake);
            loader_start <= (state_d == StLoad);
            cpu_reset    <= (state_d != StRun);
            ready        <= (state_d == StRun);
            fault        <= (state_d == StFault);
        end
    end

    assign attempts = attempts_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer with SETTLE=4, WAKE=3, LOAD_TIMEOUT=8,
// MAX_RETRIES=2. Stimulus pushes hand-computed output events (cycle + values);
// the monitor pops one whenever a pulse fires or a level output changes.
module tb_boot_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       loader_done = 1'b0;
    logic       flash_wake, loader_start, cpu_reset, ready, fault;
    logic [3:0] attempts;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          mon_en = 1'b0;

    typedef struct packed {
        logic [31:0] t;
        logic        fw;
        logic        ls;
        logic        cr;
        logic        rdy;
        logic        flt;
        logic [3:0]  att;
    } ev_t;

    ev_t        exp_q[$];
    logic [6:0] prev_lvl;

    boot_sequencer #(
        .SETTLE_CYCLES (4),
        .WAKE_CYCLES   (3),
        .LOAD_TIMEOUT  (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .loader_done  (loader_done),
        .flash_wake   (flash_wake),
        .loader_start (loader_start),
        .cpu_reset    (cpu_reset),
        .ready        (ready),
        .fault        (fault),
        .attempts     (attempts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int unsigned t, input logic fw, input logic ls, input logic cr,
                        input logic rdy, input logic flt, input logic [3:0] att);
        ev_t e;
        e.t = t; e.fw = fw; e.ls = ls; e.cr = cr; e.rdy = rdy; e.flt = flt; e.att = att;
        exp_q.push_back(e);
    endtask

    // Advance to the start of cycle t (just after its rising edge).
    task automatic goto(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // Monitor: any pulse or level change is an event to match against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [6:0] lvl;
            ev_t        e;
            lvl = {cpu_reset, ready, fault, attempts};
            if (flash_wake || loader_start || lvl != prev_lvl) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event at cycle %0d: fw=%b ls=%b cr=%b rdy=%b flt=%b att=%0d, expected none",
                             cyc, flash_wake, loader_start, cpu_reset, ready, fault, attempts);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != cyc || e.fw !== flash_wake || e.ls !== loader_start ||
                        e.cr !== cpu_reset || e.rdy !== ready || e.flt !== fault ||
                        e.att !== attempts) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d fw=%b ls=%b cr=%b rdy=%b flt=%b att=%0d, expected cyc=%0d fw=%b ls=%b cr=%b rdy=%b flt=%b att=%0d",
                                 cyc, flash_wake, loader_start, cpu_reset, ready, fault, attempts,
                                 e.t, e.fw, e.ls, e.cr, e.rdy, e.flt, e.att);
                    end
                end
            end
            prev_lvl = lvl;
        end
    end

    initial begin
        // Reset state
        goto(3);
        check("rst_cpu_reset", {3'b0, cpu_reset}, 4'd1);
        check("rst_ready", {3'b0, ready}, 4'd0);
        check("rst_fault", {3'b0, fault}, 4'd0);
        check("rst_flash_wake", {3'b0, flash_wake}, 4'd0);
        check("rst_loader_start", {3'b0, loader_start}, 4'd0);
        check("rst_attempts", attempts, 4'd0);
        reset = 1'b0;
        prev_lvl = 7'b1000000;
        mon_en = 1'b1;

        // Nominal boot: lock at 5, done 2 cycles after start
        push(10, 1, 0, 1, 0, 0, 4'd0);
        push(14, 0, 1, 1, 0, 0, 4'd1);
        push(17, 0, 0, 0, 1, 0, 4'd1);
        goto(5);  pll_locked = 1'b1;
        goto(16); loader_done = 1'b1;

        // Lock lost in RUN; rerun with loader_done still high from the last attempt
        push(21, 0, 0, 1, 0, 0, 4'd0);
        push(28, 1, 0, 1, 0, 0, 4'd0);
        push(32, 0, 1, 1, 0, 0, 4'd1);
        push(35, 0, 0, 0, 1, 0, 4'd1);
        goto(20); pll_locked = 1'b0;
        goto(23); pll_locked = 1'b1;
        goto(36); loader_done = 1'b0;

        // Lock drop in SETTLE cycle 2, then full settle, two timeouts, FAULT
        push(39, 0, 0, 1, 0, 0, 4'd0);
        push(48, 1, 0, 1, 0, 0, 4'd0);
        push(52, 0, 1, 1, 0, 0, 4'd1);
        push(60, 1, 0, 1, 0, 0, 4'd1);
        push(64, 0, 1, 1, 0, 0, 4'd2);
        push(72, 0, 0, 1, 0, 1, 4'd2);
        goto(38); pll_locked = 1'b0;
        goto(40); pll_locked = 1'b1;
        goto(42); pll_locked = 1'b0;
        goto(43); pll_locked = 1'b1;

        // Leave FAULT by lock loss; done arrives in the timeout cycle
        push(76, 0, 0, 1, 0, 0, 4'd0);
        push(83, 1, 0, 1, 0, 0, 4'd0);
        push(87, 0, 1, 1, 0, 0, 4'd1);
        push(95, 0, 0, 0, 1, 0, 4'd1);
        goto(75); pll_locked = 1'b0;
        goto(78); pll_locked = 1'b1;
        goto(94); loader_done = 1'b1;
        goto(96); loader_done = 1'b0;

        // Reset asserted in LOAD_WAIT
        push(99, 0, 0, 1, 0, 0, 4'd0);
        push(106, 1, 0, 1, 0, 0, 4'd0);
        push(110, 0, 1, 1, 0, 0, 4'd1);
        push(113, 0, 0, 1, 0, 0, 4'd0);
        goto(98);  pll_locked = 1'b0;
        goto(101); pll_locked = 1'b1;
        goto(112); reset = 1'b1; pll_locked = 1'b0;
        goto(113);
        check("rrst_cpu_reset", {3'b0, cpu_reset}, 4'd1);
        check("rrst_ready", {3'b0, ready}, 4'd0);
        check("rrst_attempts", attempts, 4'd0);
        check("rrst_loader_start", {3'b0, loader_start}, 4'd0);
        goto(114); reset = 1'b0;

        // Lock loss beats loader_done in the same cycle
        push(121, 1, 0, 1, 0, 0, 4'd0);
        push(125, 0, 1, 1, 0, 0, 4'd1);
        push(128, 0, 0, 1, 0, 0, 4'd0);
        goto(116); pll_locked = 1'b1;
        goto(127); loader_done = 1'b1; pll_locked = 1'b0;
        goto(129); loader_done = 1'b0;

        goto(135);
        check("pending_events", 4'(exp_q.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
